decimal_entry: RTL and testbench
================================

# decimal_entry

Sequential decimal-entry front end: converts operator key events (decimal digits, sign toggle, enter, clear) into a signed 8-bit two's-complement value for the processor datapath. It is the input-side counterpart of the binary-to-7-segment display path: that path renders a signed byte as sign/hundreds/tens/units, and this block builds a signed byte from those same fields. It exports a live entry echo so the display path can show digits while they are typed.

## Interface
Parameters:
- none (range fixed at -128..127, 3 decimal digits)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- Digit  in  4  BCD digit, qualified by DigitValid; values 10..15 are ignored
- DigitValid  in  1  digit event
- SignToggle  in  1  sign-flip event
- Enter  in  1  commit event
- Clear  in  1  abort/clear event
- Num  out  8  last accepted value, two's complement
- NumValid  out  1  one-cycle pulse when Num is updated
- Err  out  1  out-of-range commit; held until Clear or reset
- EntryMag  out  10  magnitude being typed (0..999)
- EntryNeg  out  1  current entry sign (1 = negative)
- EntryCount  out  2  digits accepted so far (0..3)
- State  out  2  FSM state: IDLE=2'd0, ENTRY=2'd1, ERROR=2'd2

## Operation
- Reset values: State=IDLE, Num=8'h00, NumValid=0, Err=0, EntryMag=0, EntryNeg=0, EntryCount=0.
- Single-event priority per cycle: Clear > Enter > SignToggle > DigitValid. Lower-priority events in the same cycle are dropped.
- IDLE:
  - valid digit d → EntryMag=d, EntryCount=1, EntryNeg=0, go ENTRY.
  - SignToggle → EntryNeg=1, EntryCount=0, go ENTRY.
  - Enter → ignored.
- ENTRY:
  - valid digit d with EntryCount<3 → EntryMag=EntryMag*10+d (10-bit arithmetic, max 999), EntryCount+1.
  - digit with EntryCount==3 → ignored.
  - SignToggle → EntryNeg inverted.
  - Enter with EntryCount==0 → go IDLE, no commit.
  - Enter, positive and EntryMag≤127 → Num=EntryMag[7:0], NumValid=1.
  - Enter, negative and EntryMag≤128 → Num=-EntryMag, computed as ~EntryMag[7:0]+1. -0 commits 8'h00.
  - On either successful commit, clear the entry fields and go IDLE.
  - Enter, out of range → Err=1, go ERROR. Num is unchanged and NumValid stays 0.
- ERROR: every event except Clear is ignored. Entry fields hold their values for display.
- Clear, from any state: go IDLE, zero the entry fields, Err=0. Num is retained.
- Digits 10..15 count as no event, so a lower-priority event is not blocked by them.

## Timing
- All outputs are registered. An event sampled at edge k is reflected on the outputs after edge k.
- NumValid is high for exactly one cycle after the committing edge.
- Back-to-back events on consecutive cycles are each processed. Throughput is one event per cycle.
- Reset asserted mid-entry or in ERROR applies the reset values at the next edge. Reset takes priority over all events.

## Configuration
- DECIMAL_ENTRY_EDGE_EN defined:
  - DigitValid, SignToggle, Enter and Clear are level inputs from push buttons.
  - The block registers each one and acts only on rising edges (in & ~in_q), so a level held for N cycles produces one event.
  - Edge registers reset to 0.
  - No added latency relative to the first high cycle.
- Not defined: the inputs are single-cycle pulses and every high cycle is one event.

## Test plan
- Digits 1,2,7 then Enter → Num=8'h7F, NumValid high for 1 cycle, State=IDLE, Err=0.
- SignToggle, then digits 1,2,8, then Enter → Num=8'h80.
- Digits 1,2,8 positive, then Enter → Err=1, State=ERROR, Num keeps its prior value. A digit 5 is then ignored. Clear → State=IDLE, Err=0.
- Digits 1,2,3,4 → EntryMag=123, EntryCount=3 (digit 4 ignored). Digit 4'hC is ignored. Enter → Num=8'h7B.
- Digit 9 with Enter and Clear asserted in the same cycle → Clear wins, State=IDLE, no NumValid. Separately, reset asserted mid-entry → all reset values.
- With DECIMAL_ENTRY_EDGE_EN: digits 4,2 typed, then Enter held high for 5 cycles → exactly one NumValid pulse, Num=8'h2A.

Source files
------------

// File: rtl/decimal_entry.sv
// Decimal-entry front end: turns digit/sign/enter/clear key events into a signed byte.
// Optional build macro DECIMAL_ENTRY_EDGE_EN: treat key inputs as push-button levels and act on rising edges only.
module decimal_entry (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Digit,
    input  logic       DigitValid,
    input  logic       SignToggle,
    input  logic       Enter,
    input  logic       Clear,
    output logic [7:0] Num,
    output logic       NumValid,
    output logic       Err,
    output logic [9:0] EntryMag,
    output logic       EntryNeg,
    output logic [1:0] EntryCount,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] num_q, num_d;
    logic       nv_q, nv_d;
    logic       err_q, err_d;
    logic [9:0] mag_q, mag_d;
    logic       neg_q, neg_d;
    logic [1:0] cnt_q, cnt_d;

    logic dv_ev, st_ev, en_ev, cl_ev;

`ifdef DECIMAL_ENTRY_EDGE_EN
    logic dv_q, st_q, en_q, cl_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            dv_q <= 1'b0;
            st_q <= 1'b0;
            en_q <= 1'b0;
            cl_q <= 1'b0;
        end else begin
            dv_q <= DigitValid;
            st_q <= SignToggle;
            en_q <= Enter;
            cl_q <= Clear;
        end
    end

    // Edge detect against the previous level; the first high cycle is the event.
    assign dv_ev = DigitValid & ~dv_q;
    assign st_ev = SignToggle & ~st_q;
    assign en_ev = Enter & ~en_q;
    assign cl_ev = Clear & ~cl_q;
`else
    assign dv_ev = DigitValid;
    assign st_ev = SignToggle;
    assign en_ev = Enter;
    assign cl_ev = Clear;
`endif

    logic digit_ok;
    logic do_clear, do_enter, do_sign, do_digit;

    // Non-BCD digits are no event, so they never mask anything below them.
    assign digit_ok = dv_ev & (Digit <= 4'd9);
    assign do_clear = cl_ev;
    assign do_enter = en_ev & ~cl_ev;
    assign do_sign  = st_ev & ~en_ev & ~cl_ev;
    assign do_digit = digit_ok & ~st_ev & ~en_ev & ~cl_ev;

    logic       in_range;
    logic       empty;
    logic [9:0] mag_x10;
    logic [7:0] mag_neg;

    assign in_range = neg_q ? (mag_q <= 10'd128) : (mag_q <= 10'd127);
    assign empty    = (cnt_q == 2'd0);
    assign mag_x10  = {mag_q[6:0], 3'b000} + {mag_q[8:0], 1'b0};
    assign mag_neg  = ~mag_q[7:0] + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!do_clear && (do_sign || do_digit)) begin
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (do_clear) begin
                    state_d = IDLE;
                end else if (do_enter) begin
                    state_d = (empty || in_range) ? IDLE : ERROR;
                end
            end
            ERROR: begin
                if (do_clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        num_d = num_q;
        nv_d  = 1'b0;
        err_d = err_q;
        mag_d = mag_q;
        neg_d = neg_q;
        cnt_d = cnt_q;
        if (do_clear) begin
            mag_d = '0;
            neg_d = 1'b0;
            cnt_d = '0;
            err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (do_sign) begin
                        neg_d = 1'b1;
                        cnt_d = '0;
                    end else if (do_digit) begin
                        mag_d = {6'b0, Digit};
                        cnt_d = 2'd1;
                        neg_d = 1'b0;
                    end
                end
                ENTRY: begin
                    if (do_enter) begin
                        if (!empty && in_range) begin
                            num_d = neg_q ? mag_neg : mag_q[7:0];
                            nv_d  = 1'b1;
                            mag_d = '0;
                            neg_d = 1'b0;
                            cnt_d = '0;
                        end else if (!empty) begin
                            err_d = 1'b1;
                        end
                    end else if (do_sign) begin
                        neg_d = ~neg_q;
                    end else if (do_digit && cnt_q != 2'd3) begin
                        mag_d = mag_x10 + {6'b0, Digit};
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            num_q <= '0;
            nv_q  <= 1'b0;
            err_q <= 1'b0;
            mag_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            num_q <= num_d;
            nv_q  <= nv_d;
            err_q <= err_d;
            mag_q <= mag_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
        end
    end

    assign Num        = num_q;
    assign NumValid   = nv_q;
    assign Err        = err_q;
    assign EntryMag   = mag_q;
    assign EntryNeg   = neg_q;
    assign EntryCount = cnt_q;
    assign State      = state_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Bench for decimal_entry: directed key sequences plus random key traffic against an integer reference model.
module tb_decimal_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Digit = '0;
    logic       DigitValid = 1'b0;
    logic       SignToggle = 1'b0;
    logic       Enter = 1'b0;
    logic       Clear = 1'b0;
    logic [7:0] Num;
    logic       NumValid;
    logic       Err;
    logic [9:0] EntryMag;
    logic       EntryNeg;
    logic [1:0] EntryCount;
    logic [1:0] State;

    always #5 clk = ~clk;

    decimal_entry dut (
        .clk        (clk),
        .reset      (reset),
        .Digit      (Digit),
        .DigitValid (DigitValid),
        .SignToggle (SignToggle),
        .Enter      (Enter),
        .Clear      (Clear),
        .Num        (Num),
        .NumValid   (NumValid),
        .Err        (Err),
        .EntryMag   (EntryMag),
        .EntryNeg   (EntryNeg),
        .EntryCount (EntryCount),
        .State      (State)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: 0 idle, 1 entry, 2 error; value held as a plain integer.
    int m_state = 0, m_mag = 0, m_neg = 0, m_cnt = 0, m_num = 0, m_err = 0, m_nv = 0;
    bit p_dv = 0, p_sg = 0, p_en = 0, p_cl = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit rst, input bit dv, input int d,
                                input bit sg, input bit en, input bit cl);
        bit e_dv, e_sg, e_en, e_cl;
        int v;
        if (!rst) begin
            m_state = 0; m_mag = 0; m_neg = 0; m_cnt = 0; m_num = 0; m_err = 0; m_nv = 0;
            p_dv = 0; p_sg = 0; p_en = 0; p_cl = 0;
            return;
        end
`ifdef DECIMAL_ENTRY_EDGE_EN
        e_dv = dv && !p_dv; e_sg = sg && !p_sg; e_en = en && !p_en; e_cl = cl && !p_cl;
        p_dv = dv; p_sg = sg; p_en = en; p_cl = cl;
`else
        e_dv = dv; e_sg = sg; e_en = en; e_cl = cl;
`endif
        m_nv = 0;
        if (e_cl) begin
            m_state = 0; m_mag = 0; m_cnt = 0; m_neg = 0; m_err = 0;
        end else if (e_en) begin
            if (m_state == 1) begin
                if (m_cnt == 0) begin
                    m_state = 0;
                end else begin
                    v = m_neg ? -m_mag : m_mag;
                    if (v >= -128 && v <= 127) begin
                        m_num = v & 255; m_nv = 1;
                        m_mag = 0; m_cnt = 0; m_neg = 0; m_state = 0;
                    end else begin
                        m_err = 1; m_state = 2;
                    end
                end
            end
        end else if (e_sg) begin
            if (m_state == 0) begin
                m_neg = 1; m_cnt = 0; m_state = 1;
            end else if (m_state == 1) begin
                m_neg = m_neg ? 0 : 1;
            end
        end else if (e_dv && d <= 9) begin
            if (m_state == 0) begin
                m_mag = d; m_cnt = 1; m_neg = 0; m_state = 1;
            end else if (m_state == 1 && m_cnt < 3) begin
                m_mag = m_mag * 10 + d; m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit dv, input logic [3:0] d,
                        input bit sg, input bit en, input bit cl);
        @(negedge clk);
        reset = rst; DigitValid = dv; Digit = d; SignToggle = sg; Enter = en; Clear = cl;
        @(posedge clk);
        model_update(rst, dv, 32'(d), sg, en, cl);
        #1;
        check("Num",        32'(Num),        m_num);
        check("NumValid",   32'(NumValid),   m_nv);
        check("Err",        32'(Err),        m_err);
        check("EntryMag",   32'(EntryMag),   m_mag);
        check("EntryNeg",   32'(EntryNeg),   m_neg);
        check("EntryCount", 32'(EntryCount), m_cnt);
        check("State",      32'(State),      m_state);
    endtask

    task automatic idle();
        step(1, 0, 4'd0, 0, 0, 0);
    endtask

    // Each key is a one-cycle press followed by a released cycle so it also works as a button edge.
    task automatic key_digit(input logic [3:0] d);
        step(1, 1, d, 0, 0, 0); idle();
    endtask

    task automatic key_sign();
        step(1, 0, 4'd0, 1, 0, 0); idle();
    endtask

    task automatic key_clear();
        step(1, 0, 4'd0, 0, 0, 1); idle();
    endtask

    int pulses;

    initial begin
        step(0, 0, 4'd0, 0, 0, 0);
        step(0, 1, 4'd7, 1, 1, 0);
        check("rst_num",   32'(Num),        0);
        check("rst_state", 32'(State),      0);
        check("rst_cnt",   32'(EntryCount), 0);

        key_digit(4'd1); key_digit(4'd2); key_digit(4'd7);
        step(1, 0, 4'd0, 0, 1, 0);
        check("p127_num", 32'(Num), 8'h7F);
        check("p127_nv",  32'(NumValid), 1);
        idle();
        check("p127_nv_drop", 32'(NumValid), 0);

        key_sign(); key_digit(4'd1); key_digit(4'd2); key_digit(4'd8);
        step(1, 0, 4'd0, 0, 1, 0); idle();
        check("m128_num", 32'(Num), 8'h80);

        key_digit(4'd1); key_digit(4'd2); key_digit(4'd8);
        step(1, 0, 4'd0, 0, 1, 0); idle();
        check("ovf_err",   32'(Err),   1);
        check("ovf_state", 32'(State), 2);
        check("ovf_num",   32'(Num),   8'h80);
        key_digit(4'd5);
        check("err_hold_mag", 32'(EntryMag), 128);
        key_clear();
        check("clr_state", 32'(State), 0);
        check("clr_err",   32'(Err),   0);

        key_digit(4'd1); key_digit(4'd2); key_digit(4'd3); key_digit(4'd4);
        check("cap_mag", 32'(EntryMag),   123);
        check("cap_cnt", 32'(EntryCount), 3);
        key_digit(4'hC);
        check("bad_digit", 32'(EntryMag), 123);
        step(1, 0, 4'd0, 0, 1, 0); idle();
        check("n123", 32'(Num), 8'h7B);

        key_sign(); key_digit(4'd0);
        step(1, 0, 4'd0, 0, 1, 0); idle();
        check("neg_zero", 32'(Num), 8'h00);
        key_sign(); key_digit(4'd5);
        step(1, 0, 4'd0, 0, 1, 0); idle();
        check("neg5", 32'(Num), 8'hFB);

        key_digit(4'd9);
        step(1, 1, 4'd9, 0, 1, 1);
        check("prio_state", 32'(State),    0);
        check("prio_nv",    32'(NumValid), 0);
        idle();

        key_digit(4'd4); key_digit(4'd2);
        step(0, 0, 4'd0, 0, 0, 0);
        check("midrst_mag",   32'(EntryMag), 0);
        check("midrst_state", 32'(State),    0);
        check("midrst_num",   32'(Num),      0);
        idle();

        key_digit(4'd4); key_digit(4'd2);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 4'd0, 0, 1, 0);
            if (NumValid) pulses++;
        end
        idle();
        if (NumValid) pulses++;
        check("held_pulses", pulses, 1);
        check("held_num",    32'(Num), 8'h2A);

        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_dv, r_sg, r_en, r_cl;
            logic [3:0] r_d;
            r_rst = ($urandom_range(0, 199) != 0);
            r_cl  = ($urandom_range(0, 29) == 0);
            r_en  = ($urandom_range(0, 7) == 0);
            r_sg  = ($urandom_range(0, 9) == 0);
            r_dv  = ($urandom_range(0, 1) == 1);
            r_d   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
            step(r_rst, r_dv, r_d, r_sg, r_en, r_cl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
